// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared pipeline widths and memory-stage FSM state type
package mips_pkg;
   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } memState_t;
endpackage

// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - data-memory request/response bus between MEM stage and memory
interface mem_access_if;
   import mips_pkg::*;

   logic              dm_req;
   logic              dm_we;
   logic [DATA_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_ack;

   modport master (
      output dm_req, dm_we, dm_addr, dm_wdata,
      input  dm_rdata, dm_ack
   );

   modport slave (
      input  dm_req, dm_we, dm_addr, dm_wdata,
      output dm_rdata, dm_ack
   );
endinterface

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM pipeline stage with stalling data-memory access and MEM/WB register
// Optional MEM_ACCESS_PERF_EN adds stall and completed-access counters.
module mem_access
   import mips_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_W-1:0]     alu_res_m,
   input  logic [DATA_W-1:0]     reg_d2_m,
   input  logic [REG_ADDR_W-1:0] reg_write_addr_m,
   input  logic                  reg_write_m,
   input  logic                  mem_to_reg_m,
   input  logic                  mem_write_m,
   mem_access_if.master          bus,
   output logic                  stall_m,
   output logic [DATA_W-1:0]     alu_res_w,
   output logic [DATA_W-1:0]     read_data_w,
   output logic [REG_ADDR_W-1:0] reg_write_addr_w,
   output logic                  reg_write_w,
   output logic                  mem_to_reg_w,
   output logic                  align_err
`ifdef MEM_ACCESS_PERF_EN
   ,
   output logic [DATA_W-1:0]     perf_stall_cnt,
   output logic [DATA_W-1:0]     perf_access_cnt
`endif
);

   memState_t state;
   logic      access;
   logic      aligned;
   logic      hit;
   logic      complete;

   assign access   = mem_to_reg_m | mem_write_m;
   assign aligned  = (alu_res_m[1:0] == 2'b00);
   assign hit      = access & aligned;
   assign complete = hit & bus.dm_ack;

   // Upstream holds *_m stable while stalled, so the request is driven straight from them.
   assign bus.dm_req   = hit;
   assign bus.dm_we    = hit & mem_write_m;
   assign bus.dm_addr  = alu_res_m;
   assign bus.dm_wdata = reg_d2_m;
   assign stall_m      = hit & ~bus.dm_ack;

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         alu_res_w        <= '0;
         read_data_w      <= '0;
         reg_write_addr_w <= '0;
         reg_write_w      <= 1'b0;
         mem_to_reg_w     <= 1'b0;
         align_err        <= 1'b0;
`ifdef MEM_ACCESS_PERF_EN
         perf_stall_cnt   <= '0;
         perf_access_cnt  <= '0;
`endif
      end else begin
         case (state)
            IDLE:    if (stall_m) state <= WAIT;
            WAIT:    if (!stall_m) state <= IDLE;
            default: state <= IDLE;
         endcase

         if (stall_m) begin
            reg_write_w  <= 1'b0;
            mem_to_reg_w <= 1'b0;
         end else begin
            alu_res_w        <= alu_res_m;
            reg_write_addr_w <= reg_write_addr_m;
            // A misaligned access retires without touching the register file.
            reg_write_w      <= reg_write_m & ~(access & ~aligned);
            mem_to_reg_w     <= mem_to_reg_m;
            if (complete && mem_to_reg_m)
               read_data_w <= bus.dm_rdata;
         end

         if (access && !aligned)
            align_err <= 1'b1;

`ifdef MEM_ACCESS_PERF_EN
         if (stall_m)
            perf_stall_cnt <= perf_stall_cnt + 1'b1;
         if (complete)
            perf_access_cnt <= perf_access_cnt + 1'b1;
`endif
      end
   end

endmodule
